intr_ctrl: RTL and testbench

The interrupt controller sits directly upstream of the `controller` in `cpu_top`. It turns the raw `int_in` lines into one prioritised, maskable request with a computed trap vector. It holds that request stable under a request/acknowledge handshake with the controller and saves the interrupted PC. It blocks further requests until the controller signals trap return.

---
 rtl/intr_ctrl.sv | 132 +++++++++++++
 tb/tb_intr_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Prioritised, maskable interrupt controller with request/acknowledge handshake,
// saved PC and global-enable save/restore across a single non-nested handler.
module intr_ctrl #(
  parameter int INT_WIDTH = 8,
  parameter int WIDTH     = 32,
  localparam int ID_W     = (INT_WIDTH > 1) ? $clog2(INT_WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INT_WIDTH-1:0] int_in,
  input  logic [WIDTH-1:0]     mtvec,
  input  logic [WIDTH-1:0]     pc_in,
  input  logic                 irq_ack,
  input  logic                 mret,
  input  logic                 mask_we,
  input  logic [INT_WIDTH-1:0] mask_wdata,
  input  logic                 gie_we,
  input  logic                 gie_wdata,
  output logic                 irq_req,
  output logic [ID_W-1:0]      irq_id,
  output logic [WIDTH-1:0]     irq_vector,
  output logic [WIDTH-1:0]     epc_out,
  output logic [INT_WIDTH-1:0] pending_out,
  output logic [INT_WIDTH-1:0] mask_out,
  output logic                 gie_out,
  output logic                 in_service
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [INT_WIDTH-1:0] int_prev_q, int_prev_d;
  logic [INT_WIDTH-1:0] pending_q, pending_d;
  logic [INT_WIDTH-1:0] mask_q, mask_d;
  logic                 gie_q, gie_d;
  logic                 saved_gie_q, saved_gie_d;
  logic [WIDTH-1:0]     epc_q, epc_d;
  logic [ID_W-1:0]      irq_id_q, irq_id_d;

  logic [INT_WIDTH-1:0] rise;
  logic [INT_WIDTH-1:0] qual;
  logic [INT_WIDTH-1:0] clr_mask;
  logic [ID_W-1:0]      win_id;
  logic [WIDTH-1:0]     mtvec_base;

  assign rise = int_in & ~int_prev_q;
  assign qual = pending_q & mask_q & {INT_WIDTH{gie_q}};

  // One-hot of the line being acknowledged, used to clear its pending bit.
  for (genvar gi = 0; gi < INT_WIDTH; gi++) begin : g_clr
    assign clr_mask[gi] = (irq_id_q == ID_W'(gi));
  end

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    win_id = '0;
    for (int i = INT_WIDTH - 1; i >= 0; i--) begin
      if (qual[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    int_prev_d  = int_in;
    pending_d   = pending_q | rise;
    mask_d      = mask_we ? mask_wdata : mask_q;
    gie_d       = gie_we ? gie_wdata : gie_q;
    saved_gie_d = saved_gie_q;
    epc_d       = epc_q;
    irq_id_d    = irq_id_q;
    case (state_q)
      S_IDLE: begin
        if (|qual) begin
          state_d  = S_REQ;
          irq_id_d = win_id;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          state_d     = S_SERVICE;
          epc_d       = pc_in;
          // A fresh edge on the acknowledged line keeps it pending.
          pending_d   = (pending_q & ~clr_mask) | rise;
          saved_gie_d = gie_q;
          gie_d       = 1'b0;
        end
      end
      S_SERVICE: begin
        if (mret) begin
          state_d = S_IDLE;
          gie_d   = saved_gie_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      int_prev_q  <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      gie_q       <= 1'b0;
      saved_gie_q <= 1'b0;
      epc_q       <= '0;
      irq_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      int_prev_q  <= int_prev_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      gie_q       <= gie_d;
      saved_gie_q <= saved_gie_d;
      epc_q       <= epc_d;
      irq_id_q    <= irq_id_d;
    end
  end

  assign mtvec_base  = mtvec & ~WIDTH'(3);
  assign irq_vector  = mtvec_base + (WIDTH'(irq_id_q) << 2);
  assign irq_req     = (state_q == S_REQ);
  assign in_service  = (state_q == S_SERVICE);
  assign irq_id      = irq_id_q;
  assign epc_out     = epc_q;
  assign pending_out = pending_q;
  assign mask_out    = mask_q;
  assign gie_out     = gie_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a per-cycle reference model plus literal spot checks.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_in;
  logic [31:0] mtvec;
  logic [31:0] pc_in;
  logic        irq_ack;
  logic        mret;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        gie_we;
  logic        gie_wdata;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic [31:0] irq_vector;
  logic [31:0] epc_out;
  logic [7:0]  pending_out;
  logic [7:0]  mask_out;
  logic        gie_out;
  logic        in_service;

  always #5 clk = ~clk;

  intr_ctrl #(.INT_WIDTH(8), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .int_in(int_in), .mtvec(mtvec), .pc_in(pc_in),
    .irq_ack(irq_ack), .mret(mret), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .gie_we(gie_we), .gie_wdata(gie_wdata), .irq_req(irq_req), .irq_id(irq_id),
    .irq_vector(irq_vector), .epc_out(epc_out), .pending_out(pending_out),
    .mask_out(mask_out), .gie_out(gie_out), .in_service(in_service)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  // Reference model: mode 0 = waiting, 1 = requesting, 2 = handler running.
  int          m_mode = 0;
  int          m_id = 0;
  bit [7:0]    m_pend = '0, m_mask = '0, m_prev = '0;
  bit          m_gie = 1'b0, m_sgie = 1'b0;
  logic [31:0] m_epc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    bit [7:0] rise, npend;
    bit ngie;
    int w;
    if (rst) begin
      m_mode = 0; m_id = 0; m_pend = '0; m_mask = '0; m_prev = '0;
      m_gie = 1'b0; m_sgie = 1'b0; m_epc = '0;
      return;
    end
    rise  = int_in & ~m_prev;
    npend = m_pend | rise;
    ngie  = gie_we ? gie_wdata : m_gie;
    case (m_mode)
      0: begin
        w = lowest(m_pend & m_mask & {8{m_gie}});
        if (w >= 0) begin m_mode = 1; m_id = w; end
      end
      1: if (irq_ack) begin
        m_epc = pc_in; npend[m_id] = rise[m_id];
        m_sgie = m_gie; ngie = 1'b0; m_mode = 2;
      end
      default: if (mret) begin ngie = m_sgie; m_mode = 0; end
    endcase
    if (mask_we) m_mask = mask_wdata;
    m_pend = npend;
    m_gie  = ngie;
    m_prev = int_in;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_irq_req", {31'b0, irq_req}, {31'b0, m_mode == 1});
      chk("m_in_service", {31'b0, in_service}, {31'b0, m_mode == 2});
      chk("m_irq_id", {29'b0, irq_id}, 32'(m_id));
      chk("m_vector", irq_vector, (mtvec & ~32'd3) + 32'(m_id) * 32'd4);
      chk("m_epc", epc_out, m_epc);
      chk("m_pending", {24'b0, pending_out}, {24'b0, m_pend});
      chk("m_mask", {24'b0, mask_out}, {24'b0, m_mask});
      chk("m_gie", {31'b0, gie_out}, {31'b0, m_gie});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    int_in = v; tick(); int_in = '0;
  endtask

  task automatic do_ack(input logic [31:0] pc);
    pc_in = pc; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic do_mret();
    mret = 1'b1; tick(); mret = 1'b0;
  endtask

  task automatic wr_mask(input logic [7:0] v);
    mask_we = 1'b1; mask_wdata = v; tick(); mask_we = 1'b0;
  endtask

  task automatic wr_gie(input logic v);
    gie_we = 1'b1; gie_wdata = v; tick(); gie_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; int_in = '0; mtvec = 32'h0000_1000; pc_in = '0;
    irq_ack = 1'b0; mret = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    gie_we = 1'b0; gie_wdata = 1'b0;
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_req", {31'b0, irq_req}, 32'd0);
    chk("reset_vector", irq_vector, 32'h0000_1000);

    // Single request
    wr_mask(8'hFF); wr_gie(1'b1);
    pulse(8'h08);
    chk("single_lat1", {31'b0, irq_req}, 32'd0);
    tick();
    chk("single_req", {31'b0, irq_req}, 32'd1);
    chk("single_id", {29'b0, irq_id}, 32'd3);
    chk("single_vec", irq_vector, 32'h0000_100C);
    do_ack(32'h200);
    chk("single_epc", epc_out, 32'h200);
    chk("single_pend", {24'b0, pending_out}, 32'd0);
    chk("single_gie", {31'b0, gie_out}, 32'd0);
    do_mret();
    chk("single_gie_back", {31'b0, gie_out}, 32'd1);

    // Priority and back-to-back ordering
    pulse(8'h24); tick();
    chk("prio_id", {29'b0, irq_id}, 32'd2);
    do_ack(32'h300); do_mret();
    chk("b2b_gap", {31'b0, irq_req}, 32'd0);
    tick();
    chk("b2b_req", {31'b0, irq_req}, 32'd1);
    chk("b2b_vec", irq_vector, 32'h0000_1014);
    do_ack(32'h304); do_mret();

    // Masking and global enable
    wr_mask(8'hFE); pulse(8'h01); tick(); tick();
    chk("mask_pend", {24'b0, pending_out}, 32'h01);
    chk("mask_noreq", {31'b0, irq_req}, 32'd0);
    wr_mask(8'hFF); tick();
    chk("mask_req", {31'b0, irq_req}, 32'd1);
    do_ack(32'h400); do_mret();
    wr_gie(1'b0); pulse(8'h02); tick(); tick();
    chk("gie_noreq", {31'b0, irq_req}, 32'd0);
    wr_gie(1'b1); tick();
    chk("gie_req_id", {29'b0, irq_id}, 32'd1);
    do_ack(32'h404); do_mret();

    // Frozen request while mask changes and a higher-priority line arrives
    pulse(8'h10); tick();
    mask_we = 1'b1; mask_wdata = 8'h00; int_in = 8'h01; tick(); mask_we = 1'b0;
    tick(); tick();
    chk("frozen_req", {31'b0, irq_req}, 32'd1);
    chk("frozen_id", {29'b0, irq_id}, 32'd4);
    chk("frozen_vec", irq_vector, 32'h0000_1010);
    do_ack(32'h500); do_mret(); tick();
    chk("frozen_masked", {31'b0, irq_req}, 32'd0);
    wr_mask(8'hFF); tick();
    chk("frozen_line0", {29'b0, irq_id}, 32'd0);
    int_in = '0;
    do_ack(32'h504); do_mret();

    // Level held through ack and mret must not re-trigger
    int_in = 8'h02; tick(); tick();
    do_ack(32'h600); do_mret(); tick(); tick();
    chk("level_noreq", {31'b0, irq_req}, 32'd0);
    chk("level_pend", {24'b0, pending_out}, 32'd0);
    int_in = '0; tick();

    // New edge on the acked line in the ack cycle keeps it pending
    pulse(8'h08); tick();
    int_in = 8'h08; do_ack(32'h700); int_in = '0;
    chk("collide_pend", {24'b0, pending_out}, 32'h08);
    do_mret(); tick();
    do_ack(32'h704); do_mret();

    // Reset mid-service
    pulse(8'h08); tick(); do_ack(32'h800);
    pulse(8'h30); tick();
    chk("rst_pre_pend", {24'b0, pending_out}, 32'h30);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_svc", {31'b0, in_service}, 32'd0);
    chk("rst_pend", {24'b0, pending_out}, 32'd0);
    chk("rst_epc", epc_out, 32'd0);
    do_mret();
    chk("rst_mret_gie", {31'b0, gie_out}, 32'd0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("rst_ack_ignored", {31'b0, in_service}, 32'd0);
    mtvec = 32'h0000_2003; tick();
    chk("vec_lowbits", irq_vector, 32'h0000_2000);

    // Vector wraps at WIDTH
    mtvec = 32'hFFFF_FFF0;
    wr_mask(8'hFF); wr_gie(1'b1); pulse(8'h20); tick();
    chk("vec_wrap", irq_vector, 32'h0000_0004);
    do_ack(32'h900); do_mret(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
